// File: rtl/fpu_sign_logic_pkg.sv
// fpu_sign_logic_pkg: FPU op_type encodings and addend-negation helper
package fpu_sign_logic_pkg;
  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_MUL    = 3'b010;
  localparam logic [2:0] OP_FMA    = 3'b011;
  localparam logic [2:0] OP_FMS    = 3'b100;
  localparam logic [2:0] OP_FNMADD = 3'b101;
  localparam logic [2:0] OP_FNMSUB = 3'b110;
  localparam logic [2:0] OP_RSVD   = 3'b111;
  function automatic logic is_negated_addend(input logic [2:0] op);
    return op == OP_SUB || op == OP_FMS || op == OP_FNMSUB;
  endfunction
endpackage

// File: rtl/fpu_sign_logic.sv
// fpu_sign_logic: product/result sign and effective-subtract flag, with one registered copy
module fpu_sign_logic
  import fpu_sign_logic_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       xs,
  input  logic       ys,
  input  logic       zs,
  input  logic [2:0] op_type,
  input  logic       in_valid,
  output logic       prod_sign,
  output logic       result_sign,
  output logic       z_eff_sign,
  output logic       eff_sub,
  output logic       prod_sign_q,
  output logic       result_sign_q,
  output logic       eff_sub_q,
  output logic       out_valid
);
  logic two_op, neg_prod, no_add;
  logic prod_sign_d, result_sign_d, eff_sub_d;
  always_comb begin
    two_op      = op_type == OP_ADD || op_type == OP_SUB;
    neg_prod    = op_type == OP_FNMADD || op_type == OP_FNMSUB;
    no_add      = op_type == OP_MUL || op_type == OP_RSVD;
    prod_sign   = xs ^ ys;
    z_eff_sign  = zs ^ is_negated_addend(op_type);
    // ADD/SUB sign is only preliminary; the adder fixes it after magnitude compare
    result_sign = two_op ? xs : (op_type == OP_RSVD) ? 1'b0 : prod_sign ^ neg_prod;
    eff_sub     = no_add ? 1'b0 : (two_op ? xs : prod_sign) ^ z_eff_sign;
    prod_sign_d   = in_valid ? prod_sign : prod_sign_q;
    result_sign_d = in_valid ? result_sign : result_sign_q;
    eff_sub_d     = in_valid ? eff_sub : eff_sub_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      prod_sign_q   <= 1'b0;
      result_sign_q <= 1'b0;
      eff_sub_q     <= 1'b0;
    end else begin
      out_valid     <= in_valid;
      prod_sign_q   <= prod_sign_d;
      result_sign_q <= result_sign_d;
      eff_sub_q     <= eff_sub_d;
    end
  end
endmodule

// File: tb/tb_fpu_sign_logic.sv
// tb_fpu_sign_logic: directed vector table, random stimulus vs reference model, pipeline/reset sequences
module tb_fpu_sign_logic;
  logic clk, rst_n, xs, ys, zs, in_valid;
  logic [2:0] op_type;
  logic prod_sign, result_sign, z_eff_sign, eff_sub;
  logic prod_sign_q, result_sign_q, eff_sub_q, out_valid;
  int errors = 0;
  int checks = 0;
  logic ep, er, ee;

  fpu_sign_logic dut (
    .clk(clk), .rst_n(rst_n), .xs(xs), .ys(ys), .zs(zs), .op_type(op_type),
    .in_valid(in_valid), .prod_sign(prod_sign), .result_sign(result_sign),
    .z_eff_sign(z_eff_sign), .eff_sub(eff_sub), .prod_sign_q(prod_sign_q),
    .result_sign_q(result_sign_q), .eff_sub_q(eff_sub_q), .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic x, y, z;
    logic p, r, ze, e;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (op=%b xs=%b ys=%b zs=%b)", name, act, exp, op_type, xs, ys, zs);
    end
  endtask

  // Reference: sign of x*y, optional negation of product and/or addend per operation meaning
  function automatic logic [3:0] model(input logic [2:0] op, input logic x, input logic y, input logic z);
    logic p, ze, r, e;
    bit uses_add, uses_prod, neg_p;
    p = x ^ y;
    ze = z ^ (op inside {3'd1, 3'd4, 3'd6});
    uses_prod = op inside {[3'd2:3'd6]};
    uses_add = op inside {3'd0, 3'd1, [3'd3:3'd6]};
    neg_p = op inside {3'd5, 3'd6};
    if (op == 3'd7) r = 1'b0;
    else if (!uses_prod) r = x;
    else r = neg_p ? ~p : p;
    if (!uses_add) e = 1'b0;
    else e = (uses_prod ? p : x) ^ ze;
    return {p, r, ze, e};
  endfunction

  task automatic chk_comb();
    logic [3:0] m;
    m = model(op_type, xs, ys, zs);
    chk("prod_sign", prod_sign, m[3]);
    chk("result_sign", result_sign, m[2]);
    chk("z_eff_sign", z_eff_sign, m[1]);
    chk("eff_sub", eff_sub, m[0]);
  endtask

  task automatic chk_q(input logic v);
    chk("out_valid", out_valid, v);
    chk("prod_sign_q", prod_sign_q, ep);
    chk("result_sign_q", result_sign_q, er);
    chk("eff_sub_q", eff_sub_q, ee);
  endtask

  initial begin
    logic [3:0] m;
    vecs.push_back('{3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{3'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 8; i++) begin
      logic [2:0] b;
      b = 3'(i);
      vecs.push_back('{3'd2, b[2], b[1], b[0], b[2] ^ b[1], b[2] ^ b[1], b[0], 1'b0});
    end

    rst_n = 1'b0; in_valid = 1'b1; op_type = 3'd5; xs = 0; ys = 0; zs = 0;
    repeat (2) @(posedge clk);
    #1;
    ep = 0; er = 0; ee = 0;
    chk_q(1'b0);
    chk("comb_in_reset", result_sign, 1'b1);

    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      @(negedge clk);
      op_type = vecs[i].op; xs = vecs[i].x; ys = vecs[i].y; zs = vecs[i].z;
      #1;
      chk("tbl_prod_sign", prod_sign, vecs[i].p);
      chk("tbl_result_sign", result_sign, vecs[i].r);
      chk("tbl_z_eff_sign", z_eff_sign, vecs[i].ze);
      chk("tbl_eff_sub", eff_sub, vecs[i].e);
    end
    @(posedge clk); #1;
    chk_q(1'b0);

    @(negedge clk);
    op_type = 3'd5; xs = 0; ys = 0; zs = 0; in_valid = 1'b1;
    @(posedge clk); #1;
    ep = 0; er = 1; ee = 0;
    chk_q(1'b1);
    @(negedge clk);
    op_type = 3'd2; xs = 1; ys = 0; zs = 1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk_q(1'b0);

    for (int i = 0; i < 300; i++) begin
      logic v;
      @(negedge clk);
      op_type = 3'($urandom_range(7));
      xs = 1'($urandom); ys = 1'($urandom); zs = 1'($urandom);
      v = 1'($urandom_range(3) != 0);
      in_valid = v;
      #1;
      chk_comb();
      m = model(op_type, xs, ys, zs);
      @(posedge clk); #1;
      if (v) begin ep = m[3]; er = m[2]; ee = m[0]; end
      chk_q(v);
    end

    @(negedge clk);
    op_type = 3'd6; xs = 0; ys = 1; zs = 0; in_valid = 1'b1;
    @(posedge clk); #1;
    ep = 1; er = 0; ee = 0;
    chk_q(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    ep = 0; er = 0; ee = 0;
    chk_q(1'b0);
    @(posedge clk); #1;
    chk_q(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk_q(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
